// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control unit:
//   - major opcode values recognised by the decoder
//   - FSM state encoding
//   - decoded control word layout
//   - trap cause encodings
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RFUNC = 2'b10;
    localparam logic [1:0] ALU_IFUNC = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       br_un;
        logic       a_sel;
        logic       b_sel;
        logic [2:0] imm_sel;
        logic [1:0] wb_sel;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       legal;
    } ctrl_word_t;

    function automatic logic cw_is_mem(input ctrl_word_t cw);
        return cw.is_load | cw.is_store;
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// ---------------------------------------------------------------------------
// ctrl_word_decode
// Purely combinational decode of a latched {opcode, funct3} into the
// control word the FSM registers at the end of DECODE. Any opcode not
// listed below comes out with legal=0 and every other field 0.
// Ports:
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]; only bit 1 matters (branch signedness)
//   cw      out    decoded ctrl_word_t
// ---------------------------------------------------------------------------
module ctrl_word_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_word_t cw
);

    logic unused_funct3;
    assign unused_funct3 = funct3[2] ^ funct3[0];

    always_comb begin
        cw = '0;
        case (opcode)
            OPC_OP: begin
                cw.alu_op = ALU_RFUNC;
                cw.wb_sel = WB_ALU;
                cw.legal  = 1'b1;
            end
            OPC_OP_IMM: begin
                cw.alu_op  = ALU_IFUNC;
                cw.b_sel   = 1'b1;
                cw.imm_sel = IMM_I;
                cw.wb_sel  = WB_ALU;
                cw.legal   = 1'b1;
            end
            OPC_LOAD: begin
                cw.alu_op  = ALU_ADD;
                cw.b_sel   = 1'b1;
                cw.imm_sel = IMM_I;
                cw.wb_sel  = WB_MEM;
                cw.is_load = 1'b1;
                cw.legal   = 1'b1;
            end
            OPC_STORE: begin
                cw.alu_op   = ALU_ADD;
                cw.b_sel    = 1'b1;
                cw.imm_sel  = IMM_S;
                cw.is_store = 1'b1;
                cw.legal    = 1'b1;
            end
            OPC_BRANCH: begin
                cw.alu_op    = ALU_ADD;
                cw.a_sel     = 1'b1;
                cw.b_sel     = 1'b1;
                cw.imm_sel   = IMM_B;
                cw.br_un     = funct3[1];
                cw.is_branch = 1'b1;
                cw.legal     = 1'b1;
            end
            OPC_JAL: begin
                cw.alu_op  = ALU_ADD;
                cw.a_sel   = 1'b1;
                cw.b_sel   = 1'b1;
                cw.imm_sel = IMM_J;
                cw.wb_sel  = WB_PC4;
                cw.is_jal  = 1'b1;
                cw.legal   = 1'b1;
            end
            OPC_LUI: begin
                cw.imm_sel = IMM_U;
                cw.wb_sel  = WB_IMM;
                cw.legal   = 1'b1;
            end
            OPC_AUIPC: begin
                cw.alu_op  = ALU_ADD;
                cw.a_sel   = 1'b1;
                cw.b_sel   = 1'b1;
                cw.imm_sel = IMM_U;
                cw.wb_sel  = WB_ALU;
                cw.legal   = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle control unit for the RV32I datapath. Accepts one instruction
// from fetch, decodes it, holds its control word for the rest of the
// instruction and drives one-cycle commit strobes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FETCH     | instr_ready=1, waiting for instr_valid
// DECODE    | latched opcode/funct3 decoded; illegal -> TRAP
// EXECUTE   | branch resolves here; loads/stores arm the timeout
// MEM       | mem_req held until mem_ack or timeout
// WRITEBACK | reg_wen + pc_wen strobe
// TRAP      | trap=1, cause held until trap_clr
//
// Optional build macro: MCF_RETIRE_CNT_EN adds retire_cnt[31:0], counting
// pc_wen strobes (wraps).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid / instr_ready  fetch handshake (ready only in FETCH)
//   opcode, funct3             instruction fields, sampled on accept
//   br_taken                   branch result, used in EXECUTE
//   mem_req / mem_rw / mem_ack data memory handshake (mem_rw=1 store)
//   trap_clr                   leave TRAP
//   alu_op, br_un, a_sel, b_sel, imm_sel, wb_sel  registered selects
//   reg_wen, pc_wen, pc_sel    commit strobes
//   trap, trap_cause           trap status
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        br_taken,
    input  logic        mem_ack,
    input  logic        trap_clr,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [1:0]  alu_op,
    output logic        br_un,
    output logic        a_sel,
    output logic        b_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  wb_sel,
    output logic        reg_wen,
    output logic        pc_wen,
    output logic        pc_sel,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MCF_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    // Down-counter: loaded with MEM_TIMEOUT-1 on entry to MEM, so the
    // terminal count is reached in the MEM_TIMEOUT-th cycle without ack.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    ctrl_word_t      cw_q, cw_d, dec_cw;
    logic [6:0]      opc_q;
    logic [2:0]      f3_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]      cause_q, cause_d;

    logic unused_legal;
    assign unused_legal = cw_q.legal;

    ctrl_word_decode u_decode (
        .opcode (opc_q),
        .funct3 (f3_q),
        .cw     (dec_cw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            cw_q     <= '0;
            opc_q    <= '0;
            f3_q     <= '0;
            to_cnt_q <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            cw_q     <= cw_d;
            to_cnt_q <= to_cnt_d;
            cause_q  <= cause_d;
            if (state_q == FETCH && instr_valid) begin
                opc_q <= opcode;
                f3_q  <= funct3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cw_d        = cw_q;
        to_cnt_d    = to_cnt_q;
        cause_d     = cause_q;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_rw      = 1'b0;
        reg_wen     = 1'b0;
        pc_wen      = 1'b0;
        pc_sel      = 1'b0;
        trap        = 1'b0;

        case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                cw_d        = '0;
                if (instr_valid) state_d = DECODE;
            end
            DECODE: begin
                if (!dec_cw.legal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                    cw_d    = '0;
                end else begin
                    state_d = EXECUTE;
                    cw_d    = dec_cw;
                end
            end
            EXECUTE: begin
                if (cw_is_mem(cw_q)) begin
                    state_d  = MEM;
                    to_cnt_d = TO_LOAD;
                end else if (cw_q.is_branch) begin
                    pc_wen  = 1'b1;
                    pc_sel  = br_taken;
                    state_d = FETCH;
                    cw_d    = '0;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_rw  = cw_q.is_store;
                // An ack arriving on the terminal-count cycle completes the access.
                if (mem_ack) begin
                    if (cw_q.is_store) begin
                        pc_wen  = 1'b1;
                        state_d = FETCH;
                        cw_d    = '0;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (to_cnt_q == '0) begin
                    state_d = TRAP;
                    cause_d = CAUSE_MEM_TO;
                    cw_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            WRITEBACK: begin
                reg_wen = 1'b1;
                pc_wen  = 1'b1;
                pc_sel  = cw_q.is_jal;
                state_d = FETCH;
                cw_d    = '0;
            end
            TRAP: begin
                trap = 1'b1;
                if (trap_clr) begin
                    state_d = FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = FETCH;
                cw_d    = '0;
            end
        endcase
    end

    assign alu_op     = cw_q.alu_op;
    assign br_un      = cw_q.br_un;
    assign a_sel      = cw_q.a_sel;
    assign b_sel      = cw_q.b_sel;
    assign imm_sel    = cw_q.imm_sel;
    assign wb_sel     = cw_q.wb_sel;
    assign trap_cause = cause_q;

`ifdef MCF_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retire_q <= '0;
        else if (pc_wen) retire_q <= retire_q + 32'd1;
    end

    assign retire_cnt = retire_q;
`endif

endmodule
